// File: rtl/rv32_hazard_scoreboard.sv
// rv32_hazard_scoreboard: forwarding select, long-latency scoreboard and stall/flush control for the RV32 pipeline
module rv32_hazard_scoreboard #(
  parameter int NUM_FWD = 3,
  parameter int NUM_LU = 2,
  parameter int FETCH_DEPTH = 2,
  parameter int FW = $clog2(NUM_FWD + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_FWD-1:0]   fwd_we_i,
  input  logic [5*NUM_FWD-1:0] fwd_rd_i,
  input  logic [4:0]           rs1_e_i,
  input  logic [4:0]           rs2_e_i,
  input  logic [4:0]           rs1_d_i,
  input  logic [4:0]           rs2_d_i,
  input  logic [4:0]           rd_d_i,
  input  logic                 reg_write_d_i,
  input  logic [NUM_LU-1:0]    lu_req_d_i,
  input  logic [4:0]           rd_e_i,
  input  logic                 reg_write_e_i,
  input  logic                 load_e_i,
  input  logic [NUM_LU-1:0]    lu_sel_e_i,
  input  logic [NUM_LU-1:0]    lu_done_i,
  input  logic                 pc_src_e_i,
  output logic [FW-1:0]        forward_a_o,
  output logic [FW-1:0]        forward_b_o,
  output logic                 stall_f_o,
  output logic                 stall_d_o,
  output logic                 stall_e_o,
  output logic                 stall_m_o,
  output logic                 stall_w_o,
  output logic                 flush_d_o,
  output logic                 flush_e_o,
  output logic [NUM_LU-1:0]    lu_busy_o
);
  localparam int CW = FETCH_DEPTH > 1 ? $clog2(FETCH_DEPTH) : 1;
  logic [31:0] pend_q, pend_n;
  logic [NUM_LU-1:0] busy_q, busy_n;
  logic [NUM_LU-1:0][4:0] urd_q, urd_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic freeze, use_stall, raw_stall, waw_stall, struct_stall, d_stall, cnt_nz;
  always_comb begin
    forward_a_o = '0;
    forward_b_o = '0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (fwd_we_i[k] && fwd_rd_i[5*k +: 5] == rs1_e_i && rs1_e_i != 5'd0) forward_a_o = FW'(k + 1);
      if (fwd_we_i[k] && fwd_rd_i[5*k +: 5] == rs2_e_i && rs2_e_i != 5'd0) forward_b_o = FW'(k + 1);
    end
  end
  assign freeze = |lu_done_i;
  assign cnt_nz = cnt_q != '0;
  assign use_stall = reg_write_e_i && (load_e_i || |lu_sel_e_i) && rd_e_i != 5'd0 &&
                     (rd_e_i == rs1_d_i || rd_e_i == rs2_d_i);
  assign raw_stall = (rs1_d_i != 5'd0 && pend_q[rs1_d_i]) || (rs2_d_i != 5'd0 && pend_q[rs2_d_i]);
  assign waw_stall = reg_write_d_i && rd_d_i != 5'd0 && pend_q[rd_d_i];
  assign struct_stall = |(lu_req_d_i & busy_q);
  assign d_stall = use_stall || raw_stall || waw_stall || struct_stall;
  // freeze outranks the redirect: the branch stays in E and re-presents next cycle
  assign stall_f_o = freeze || (!pc_src_e_i && d_stall);
  assign stall_d_o = stall_f_o;
  assign stall_e_o = freeze;
  assign stall_m_o = freeze;
  assign stall_w_o = freeze;
  assign flush_d_o = !freeze && (pc_src_e_i || cnt_nz);
  assign flush_e_o = !freeze && (pc_src_e_i || d_stall);
  assign lu_busy_o = busy_q;
  assign cnt_n = freeze ? cnt_q : pc_src_e_i ? CW'(FETCH_DEPTH - 1) : cnt_nz ? cnt_q - 1'b1 : cnt_q;
  always_comb begin
    pend_n = pend_q;
    busy_n = busy_q;
    urd_n = urd_q;
    for (int k = 0; k < NUM_LU; k++) begin
      if (lu_done_i[k]) begin
        busy_n[k] = 1'b0;
        pend_n[urd_q[k]] = 1'b0;
      end
    end
    // sets follow clears so a same-cycle set on the same register wins
    for (int k = 0; k < NUM_LU; k++) begin
      if (lu_sel_e_i[k] && !freeze) begin
        busy_n[k] = 1'b1;
        urd_n[k] = rd_e_i;
        if (reg_write_e_i && rd_e_i != 5'd0) pend_n[rd_e_i] = 1'b1;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= '0;
      busy_q <= '0;
      urd_q <= '0;
      cnt_q <= '0;
    end else begin
      pend_q <= pend_n;
      busy_q <= busy_n;
      urd_q <= urd_n;
      cnt_q <= cnt_n;
    end
  end
endmodule

// File: tb/tb_rv32_hazard_scoreboard.sv
// tb_rv32_hazard_scoreboard: table-driven combinational vectors plus scoreboard, redirect and reset sequences
module tb_rv32_hazard_scoreboard;
  logic clk = 1'b0, rst;
  logic [2:0] fwd_we;
  logic [14:0] fwd_rd;
  logic [4:0] rs1_e, rs2_e, rs1_d, rs2_d, rd_d, rd_e;
  logic reg_write_d, reg_write_e, load_e, pc_src;
  logic [1:0] lu_req_d, lu_sel_e, lu_done, lu_busy, fa, fb;
  logic stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e;
  int nchk = 0, nerr = 0;
  always #5 clk = ~clk;
  rv32_hazard_scoreboard #(.NUM_FWD(3), .NUM_LU(2), .FETCH_DEPTH(3)) dut (
    .clk_i(clk), .rst_i(rst), .fwd_we_i(fwd_we), .fwd_rd_i(fwd_rd),
    .rs1_e_i(rs1_e), .rs2_e_i(rs2_e), .rs1_d_i(rs1_d), .rs2_d_i(rs2_d), .rd_d_i(rd_d),
    .reg_write_d_i(reg_write_d), .lu_req_d_i(lu_req_d), .rd_e_i(rd_e),
    .reg_write_e_i(reg_write_e), .load_e_i(load_e), .lu_sel_e_i(lu_sel_e),
    .lu_done_i(lu_done), .pc_src_e_i(pc_src), .forward_a_o(fa), .forward_b_o(fb),
    .stall_f_o(stall_f), .stall_d_o(stall_d), .stall_e_o(stall_e), .stall_m_o(stall_m),
    .stall_w_o(stall_w), .flush_d_o(flush_d), .flush_e_o(flush_e), .lu_busy_o(lu_busy));
  typedef struct {
    string name;
    logic [2:0] we;
    logic [14:0] frd;
    logic [4:0] rs1e, rs2e, rs1d, rs2d, rde;
    logic rwe, ld;
    logic [1:0] efa, efb;
    logic [4:0] est;
    logic [1:0] efl;
  } vec_t;
  vec_t tbl[$];
  function automatic logic [4:0] stalls();
    return {stall_f, stall_d, stall_e, stall_m, stall_w};
  endfunction
  function automatic logic [1:0] flushes();
    return {flush_d, flush_e};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic add(input string n, input logic [2:0] we, input logic [14:0] frd,
                     input logic [4:0] rs1e, rs2e, rs1d, rs2d, rde, input logic rwe, ld,
                     input logic [1:0] efa, efb, input logic [4:0] est, input logic [1:0] efl);
    vec_t v;
    v.name = n; v.we = we; v.frd = frd; v.rs1e = rs1e; v.rs2e = rs2e; v.rs1d = rs1d;
    v.rs2d = rs2d; v.rde = rde; v.rwe = rwe; v.ld = ld; v.efa = efa; v.efb = efb;
    v.est = est; v.efl = efl;
    tbl.push_back(v);
  endtask
  task automatic clr();
    fwd_we = '0; fwd_rd = '0; rs1_e = '0; rs2_e = '0; rs1_d = '0; rs2_d = '0; rd_d = '0;
    rd_e = '0; reg_write_d = 0; reg_write_e = 0; load_e = 0; pc_src = 0;
    lu_req_d = '0; lu_sel_e = '0; lu_done = '0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic ctl(input string n, input logic [4:0] est, input logic [1:0] efl);
    #1;
    chk({n, "_stall"}, 32'(stalls()), 32'(est));
    chk({n, "_flush"}, 32'(flushes()), 32'(efl));
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    clr();
    rst = 1;
    tick();
    tick();
    rst = 0;
    #1;
    chk("reset_busy", 32'(lu_busy), 0);
    chk("reset_fwd", 32'({fa, fb}), 0);
    ctl("reset", 5'b00000, 2'b00);
    add("zero",       3'b000, {5'd0, 5'd0, 5'd0}, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 2'b00);
    add("fwd_all",    3'b111, {5'd5, 5'd5, 5'd5}, 5, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00000, 2'b00);
    add("fwd_no0",    3'b110, {5'd5, 5'd5, 5'd5}, 5, 0, 0, 0, 0, 0, 0, 2, 0, 5'b00000, 2'b00);
    add("fwd_x0",     3'b111, {5'd5, 5'd5, 5'd5}, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 2'b00);
    add("fwd_b_src2", 3'b100, {5'd3, 5'd0, 5'd0}, 0, 3, 0, 0, 0, 0, 0, 0, 3, 5'b00000, 2'b00);
    add("fwd_ab",     3'b011, {5'd0, 5'd8, 5'd9}, 8, 9, 0, 0, 0, 0, 0, 2, 1, 5'b00000, 2'b00);
    add("fwd_mixed",  3'b111, {5'd3, 5'd2, 5'd1}, 3, 1, 0, 0, 0, 0, 0, 3, 1, 5'b00000, 2'b00);
    add("fwd_miss",   3'b001, {5'd0, 5'd0, 5'd5}, 6, 6, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 2'b00);
    add("load_use",   3'b000, {5'd0, 5'd0, 5'd0}, 0, 0, 0, 7, 7, 1, 1, 0, 0, 5'b11000, 2'b01);
    add("load_rd0",   3'b000, {5'd0, 5'd0, 5'd0}, 0, 0, 0, 7, 0, 1, 1, 0, 0, 5'b00000, 2'b00);
    add("load_nowr",  3'b000, {5'd0, 5'd0, 5'd0}, 0, 0, 7, 0, 7, 0, 1, 0, 0, 5'b00000, 2'b00);
    add("alu_dep",    3'b000, {5'd0, 5'd0, 5'd0}, 0, 0, 7, 0, 7, 1, 0, 0, 0, 5'b00000, 2'b00);
    foreach (tbl[i]) begin
      tick();
      clr();
      fwd_we = tbl[i].we; fwd_rd = tbl[i].frd; rs1_e = tbl[i].rs1e; rs2_e = tbl[i].rs2e;
      rs1_d = tbl[i].rs1d; rs2_d = tbl[i].rs2d; rd_e = tbl[i].rde;
      reg_write_e = tbl[i].rwe; load_e = tbl[i].ld;
      #1;
      chk({tbl[i].name, "_fa"}, 32'(fa), 32'(tbl[i].efa));
      chk({tbl[i].name, "_fb"}, 32'(fb), 32'(tbl[i].efb));
      ctl(tbl[i].name, tbl[i].est, tbl[i].efl);
    end
    // scoreboard RAW on unit 0
    tick(); clr();
    lu_sel_e = 2'b01; reg_write_e = 1; rd_e = 9; rs1_d = 9;
    ctl("lu_use", 5'b11000, 2'b01);
    for (int i = 0; i < 10; i++) begin
      tick(); clr();
      rs1_d = 9;
      ctl("raw_wait", 5'b11000, 2'b01);
      chk("raw_busy", 32'(lu_busy), 1);
    end
    tick(); lu_done = 2'b01;
    ctl("raw_done", 5'b11111, 2'b00);
    tick(); lu_done = 2'b00;
    ctl("raw_after", 5'b00000, 2'b00);
    chk("raw_after_busy", 32'(lu_busy), 0);
    // structural and WAW on unit 1
    tick(); clr();
    lu_sel_e = 2'b10; reg_write_e = 1; rd_e = 4;
    tick(); clr();
    lu_req_d = 2'b10;
    ctl("struct", 5'b11000, 2'b01);
    chk("struct_busy", 32'(lu_busy), 2);
    tick(); lu_req_d = 2'b01;
    ctl("struct_free", 5'b00000, 2'b00);
    tick(); lu_req_d = 2'b00; reg_write_d = 1; rd_d = 4;
    ctl("waw", 5'b11000, 2'b01);
    tick(); rd_d = 6;
    ctl("waw_other", 5'b00000, 2'b00);
    tick(); clr(); lu_done = 2'b10;
    tick(); clr();
    chk("u1_cleared", 32'(lu_busy), 0);
    // dispatch during freeze is dropped
    tick(); lu_sel_e = 2'b01; reg_write_e = 1; rd_e = 13; lu_done = 2'b10;
    tick(); clr(); rs1_d = 13;
    #1;
    chk("frz_disp_busy", 32'(lu_busy), 0);
    ctl("frz_disp", 5'b00000, 2'b00);
    // redirect window, FETCH_DEPTH = 3
    tick(); clr(); pc_src = 1;
    ctl("redir_t0", 5'b00000, 2'b11);
    tick(); pc_src = 0;
    ctl("redir_t1", 5'b00000, 2'b10);
    tick();
    ctl("redir_t2", 5'b00000, 2'b10);
    tick();
    ctl("redir_t3", 5'b00000, 2'b00);
    // redirect with a freeze at t+1 stretches the window
    tick(); pc_src = 1;
    ctl("rf_t0", 5'b00000, 2'b11);
    tick(); pc_src = 0; lu_done = 2'b01;
    ctl("rf_t1", 5'b11111, 2'b00);
    tick(); lu_done = 2'b00;
    ctl("rf_t2", 5'b00000, 2'b10);
    tick();
    ctl("rf_t3", 5'b00000, 2'b10);
    tick();
    ctl("rf_t4", 5'b00000, 2'b00);
    // freeze masks a redirect entirely
    tick(); pc_src = 1; lu_done = 2'b10;
    ctl("frz_redir", 5'b11111, 2'b00);
    tick(); clr();
    ctl("frz_redir_next", 5'b00000, 2'b00);
    // reset mid-operation
    tick(); lu_sel_e = 2'b01; reg_write_e = 1; rd_e = 12;
    tick(); clr(); rs1_d = 12;
    ctl("pre_rst", 5'b11000, 2'b01);
    chk("pre_rst_busy", 32'(lu_busy), 1);
    rst = 1;
    tick(); rst = 0;
    ctl("post_rst", 5'b00000, 2'b00);
    chk("post_rst_busy", 32'(lu_busy), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
